// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bus between an operand-issuing controller and
// alu_seq.
//   Request side : in_valid, in_ready, op {x,y,z,w}, ci, a, b
//   Result side  : out_valid, out_ready, g, g_hi, c_out, zero, neg, ovf, err
//   master = controller/consumer view, slave = ALU view.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_hi;
  logic             c_out;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, op, ci, a, b, out_ready,
    input  in_ready, out_valid, g, g_hi, c_out, zero, neg, ovf, err
  );

  modport slave (
    input  in_valid, op, ci, a, b, out_ready,
    output in_ready, out_valid, g, g_hi, c_out, zero, neg, ovf, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with valid/ready handshake, status flags and
// a multi-cycle unsigned shift-add multiply.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (request a/b/op/ci, result g/g_hi + flags)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no result pending, in_ready=1
// S_MUL  | shift-add multiply running, in_ready=0, in_valid ignored
// S_DONE | result held with out_valid=1, in_ready follows out_ready
module alu_seq #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplr_q;

  logic             accept;
  logic             is_add, is_sub, is_and, is_or, is_xor, is_mul;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] res_g_d;
  logic             res_c_d;
  logic             res_ovf_d;
  logic             res_err_d;
  logic [WIDTH:0]   step_sum_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplr_d;

  always_comb begin
    case (state_q)
      S_IDLE:  bus.in_ready = 1'b1;
      S_MUL:   bus.in_ready = 1'b0;
      S_DONE:  bus.in_ready = bus.out_ready;
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready;

  // Single-cycle result, computed straight from the request so it can be
  // registered on the accept edge.
  always_comb begin
    is_add = (bus.op[3:1] == 3'b010);
    is_sub = (bus.op[3:1] == 3'b110);
    is_and = (bus.op == 4'b0010);
    is_or  = (bus.op == 4'b0011);
    is_xor = (bus.op == 4'b0000);
    is_mul = (bus.op == 4'b0001);

    b_eff = is_sub ? ~bus.b : bus.b;
    sum_d = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ci};

    res_g_d   = '0;
    res_c_d   = 1'b0;
    res_ovf_d = 1'b0;
    res_err_d = 1'b0;
    if (is_add || is_sub) begin
      res_g_d   = sum_d[WIDTH-1:0];
      res_c_d   = sum_d[WIDTH];
      // Signed overflow: both addends share a sign the sum does not.
      res_ovf_d = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_d[WIDTH-1] != bus.a[WIDTH-1]);
    end else if (is_and) begin
      res_g_d = bus.a & bus.b;
    end else if (is_or) begin
      res_g_d = bus.a | bus.b;
    end else if (is_xor) begin
      res_g_d = bus.a ^ bus.b;
    end else if (!is_mul) begin
      res_err_d = 1'b1;
    end
  end

  // One multiply step: conditionally add the multiplicand into the upper
  // half, then shift {acc, multiplier} right with the adder carry entering.
  always_comb begin
    step_sum_d = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, a_q} : '0);
    acc_d      = step_sum_d[WIDTH:1];
    mplr_d     = {step_sum_d[0], mplr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      acc_q         <= '0;
      mplr_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.g         <= '0;
      bus.g_hi      <= '0;
      bus.c_out     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.neg       <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q       <= S_DONE;
            bus.out_valid <= 1'b1;
            bus.g         <= mplr_d;
            bus.g_hi      <= acc_d;
            bus.c_out     <= 1'b0;
            bus.zero      <= (mplr_d == '0);
            bus.neg       <= mplr_d[WIDTH-1];
            bus.ovf       <= (acc_d != '0);
            bus.err       <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (is_mul) begin
              state_q       <= S_MUL;
              cnt_q         <= CNT_W'(WIDTH);
              a_q           <= bus.a;
              acc_q         <= '0;
              mplr_q        <= bus.b;
              bus.out_valid <= 1'b0;
            end else begin
              state_q       <= S_DONE;
              bus.out_valid <= 1'b1;
              bus.g         <= res_g_d;
              bus.g_hi      <= '0;
              bus.c_out     <= res_c_d;
              bus.zero      <= (res_g_d == '0);
              bus.neg       <= res_g_d[WIDTH-1];
              bus.ovf       <= res_ovf_d;
              bus.err       <= res_err_d;
            end
          end else if (state_q == S_DONE && bus.out_ready) begin
            // Result consumed with no follow-on request; data holds.
            state_q       <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(4)) bus4 ();
  alu_seq_if #(.WIDTH(8)) bus8 ();

  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int errors = 0;
  int checks = 0;

  // {out_valid, in_ready, g, g_hi, c_out, zero, neg, ovf, err}
  logic [14:0] obs4, exp4;
  logic [22:0] obs8, exp8;
  logic [1:0]  hs;

  assign obs4 = {bus4.out_valid, bus4.in_ready, bus4.g, bus4.g_hi,
                 bus4.c_out, bus4.zero, bus4.neg, bus4.ovf, bus4.err};
  assign obs8 = {bus8.out_valid, bus8.in_ready, bus8.g, bus8.g_hi,
                 bus8.c_out, bus8.zero, bus8.neg, bus8.ovf, bus8.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp4 = {2'b01, 4'b0000, 4'b0000, 5'b00000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL reset4: got %b want %b", obs4, exp4);
    end
    exp8 = {2'b01, 8'h00, 8'h00, 5'b00000};
    checks++;
    if (obs8 !== exp8) begin
      errors++;
      $display("FAIL reset8: got %b want %b", obs8, exp8);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL idle4_after_reset: got %b want %b", obs4, exp4);
    end
  endtask

  task automatic test_add();
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.ci = 1'b0; bus4.op = 4'b0100;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    exp4 = {2'b10, 4'b0110, 4'b0000, 5'b10010};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL add: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b1;
    tick();
    exp4 = {2'b01, 4'b0110, 4'b0000, 5'b10010};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL add_release: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.ci = 1'b1; bus4.op = 4'b1100;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    tick();
    exp4 = {2'b10, 4'b0010, 4'b0000, 5'b10000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL sub: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b1;
    bus4.op = 4'b0010;
    tick();
    exp4 = {2'b11, 4'b1000, 4'b0000, 5'b00100};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL b2b_and: got %b want %b", obs4, exp4);
    end
    bus4.op = 4'b0011;
    tick();
    exp4 = {2'b11, 4'b1110, 4'b0000, 5'b00100};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL b2b_or: got %b want %b", obs4, exp4);
    end
    bus4.op = 4'b0000;
    tick();
    exp4 = {2'b11, 4'b0110, 4'b0000, 5'b00000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL b2b_xor: got %b want %b", obs4, exp4);
    end
    bus4.in_valid = 1'b0;
    tick();
    exp4 = {2'b01, 4'b0110, 4'b0000, 5'b00000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL b2b_idle: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_mul4_backpressure();
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.ci = 1'b0; bus4.op = 4'b0001;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    tick();
    // Keep requesting an ADD while busy; it must be ignored.
    bus4.op = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      hs = {bus4.out_valid, bus4.in_ready};
      checks++;
      if (hs !== 2'b00) begin
        errors++;
        $display("FAIL mul4_busy[%0d]: got valid/ready=%b want 00", i, hs);
      end
      tick();
    end
    exp4 = {2'b10, 4'b1000, 4'b0111, 5'b00110};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL mul4: got %b want %b", obs4, exp4);
    end
    bus4.a = 4'b0001; bus4.b = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs4 !== exp4) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %b want %b", i, obs4, exp4);
      end
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    exp4 = {2'b01, 4'b1000, 4'b0111, 5'b00110};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL backpressure_release: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_mul8();
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.ci = 1'b1; bus8.op = 4'b0001;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    tick();
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hs = {bus8.out_valid, bus8.in_ready};
      checks++;
      if (hs !== 2'b00) begin
        errors++;
        $display("FAIL mul8_busy[%0d]: got valid/ready=%b want 00", i, hs);
      end
      tick();
    end
    exp8 = {2'b10, 8'h01, 8'hFE, 5'b00010};
    checks++;
    if (obs8 !== exp8) begin
      errors++;
      $display("FAIL mul8_ff: got %b want %b", obs8, exp8);
    end
    // New MUL accepted straight from DONE drops out_valid.
    bus8.a = 8'h02; bus8.b = 8'h03;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hs = {bus8.out_valid, bus8.in_ready};
      checks++;
      if (hs !== 2'b00) begin
        errors++;
        $display("FAIL mul8_b2b_busy[%0d]: got valid/ready=%b want 00", i, hs);
      end
      tick();
    end
    exp8 = {2'b10, 8'h06, 8'h00, 5'b00000};
    checks++;
    if (obs8 !== exp8) begin
      errors++;
      $display("FAIL mul8_b2b: got %b want %b", obs8, exp8);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.ci = 1'b1; bus4.op = 4'b0110;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    tick();
    exp4 = {2'b11, 4'b0000, 4'b0000, 5'b01001};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL illegal_0110: got %b want %b", obs4, exp4);
    end
    bus4.op = 4'b1111;
    tick();
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL illegal_1111: got %b want %b", obs4, exp4);
    end
    bus4.a = 4'b0001; bus4.b = 4'b0010; bus4.ci = 1'b0; bus4.op = 4'b0100;
    tick();
    exp4 = {2'b11, 4'b0011, 4'b0000, 5'b00000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL err_clear_add: got %b want %b", obs4, exp4);
    end
    bus4.in_valid = 1'b0;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mul();
    bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.ci = 1'b0; bus4.op = 4'b0001;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp4 = {2'b01, 4'b0000, 4'b0000, 5'b00000};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL reset_in_mul4: got %b want %b", obs4, exp4);
    end
    exp8 = {2'b01, 8'h00, 8'h00, 5'b00000};
    checks++;
    if (obs8 !== exp8) begin
      errors++;
      $display("FAIL reset_in_mul8: got %b want %b", obs8, exp8);
    end
    tick();
    rst_n = 1'b1;
    bus4.a = 4'b0011; bus4.b = 4'b0100; bus4.ci = 1'b1; bus4.op = 4'b0100;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    exp4 = {2'b10, 4'b1000, 4'b0000, 5'b00110};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL add_after_reset: got %b want %b", obs4, exp4);
    end
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.op = 4'b0000;
    bus4.ci = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.op = 4'b0000;
    bus8.ci = 1'b0; bus8.a = '0; bus8.b = '0;
    tick();
    tick();
    test_reset();
    test_add();
    test_back_to_back();
    test_mul4_backpressure();
    test_mul8();
    test_illegal();
    test_reset_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
